branch_cond_unit: RTL and testbench
===================================

Name: branch_cond_unit

Overview:
- Parametrised successor to the combinational jump-condition mux.
- Holds a registered S/Z/C/V flag set and evaluates 16 branch conditions, including a hardware loop-counter condition.
- Issues a registered, one-cycle redirect pulse with target to the fetch stage.
- Sits between the ALU writeback and the program counter.

Parameters:
WIDTH, 16, datapath width of result, target and loop counter
LC_WIDTH, 16, loop-counter width (must be <= WIDTH)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous active-high reset
i_flagWe  input  1  capture new flags this cycle
i_result  input  WIDTH  ALU result; S = MSB, Z = NOR of all bits
i_carry  input  1  ALU carry-out -> C
i_ovf  input  1  ALU signed overflow -> V
i_jValid  input  1  branch instruction present this cycle
i_jCode  input  4  condition code
i_jTarget  input  WIDTH  branch target address
i_lcLoad  input  1  load loop counter
i_lcVal  input  LC_WIDTH  loop counter load value
o_flags  output  4  registered {S,Z,C,V}
o_redirect  output  1  one-cycle pulse: branch taken
o_target  output  WIDTH  registered target, valid while o_redirect=1
o_lcZero  output  1  registered, loop counter == 0

Behaviour:
- Reset (async, immediate): flags=4'b0000, o_redirect=0, o_target=0, loop counter=0, o_lcZero=1.
- Flag update: on a clock edge with i_flagWe=1, flags <= {i_result[MSB], ~|i_result, i_carry, i_ovf}. Otherwise flags are held.
- Forwarding: when i_flagWe and i_jValid are both set in the same cycle, the condition is evaluated on the incoming flags, not the registered ones.
- Condition codes. Eval flags are the forwarded or registered set.
  - 0 AL: 1
  - 1 EQ: Z
  - 2 NE: ~Z
  - 3 CS: C
  - 4 CC: ~C
  - 5 MI: S
  - 6 PL: ~S
  - 7 VS: V
  - 8 VC: ~V
  - 9 HI: C&~Z
  - 10 LS: ~C|Z
  - 11 GE: S==V
  - 12 LT: S!=V
  - 13 GT: ~Z&(S==V)
  - 14 LE: Z|(S!=V)
  - 15 LNZ: see the loop-counter section below.
- LNZ (code 15):
  - Effective counter is i_lcVal if i_lcLoad=1 that cycle, otherwise the registered counter.
  - Taken iff effective counter != 0.
  - If taken, the counter is written with effective-1.
  - If not taken, the counter stays 0.
- Loop counter priority:
  - A load without an LNZ in the same cycle writes i_lcVal.
  - An LNZ in the same cycle as a load applies the decrement on top of the loaded value.
  - Non-LNZ codes never modify the counter.
- The counter never wraps below 0.
- o_lcZero reflects the counter register after the edge.
- Latency: i_jValid at cycle N -> o_redirect at cycle N+1 for exactly one cycle when the condition is true; 0 otherwise.
- o_target <= i_jTarget on every cycle with i_jValid=1, taken or not; held otherwise.
- Back-to-back i_jValid on consecutive cycles is legal. Each produces an independent pulse, so o_redirect may stay high for several cycles.
- With i_jValid=0: o_redirect=0 next cycle; flags and the loop counter update only via their own enables.
- Reset asserted mid-loop clears the counter and any pending pulse immediately. The first post-reset LNZ without a load is not taken.

Test Plan:
- Reset, then i_flagWe with i_result=16'h0000, C=1 -> o_flags=4'b0110. A following EQ jump to 16'h0040 -> o_redirect=1 next cycle, o_target=16'h0040. NE -> o_redirect=0.
- Same-cycle i_flagWe (result 16'h8000, V=0) and LT jump -> taken via forwarding, o_redirect=1 one cycle later. Registered flags become 4'b1000.
- Signed compare: result 16'h7FFF, V=1 -> GE not taken, LT taken. Result 16'h0000, V=0 -> GT not taken, LE taken.
- i_lcLoad=3 then four consecutive LNZ jumps -> o_redirect pattern 1,1,1,0. o_lcZero=1 after the third, and the counter stays 0 after the fourth.
- Same-cycle i_lcLoad=1 with LNZ -> taken and o_lcZero=1 next cycle. With i_lcLoad=0 on the load value plus LNZ -> not taken.
- Assert i_rst while the counter is 5 and a taken jump is in flight -> o_redirect, o_target, flags and counter clear asynchronously. Post-reset LNZ is not taken.

Source files
------------

// File: rtl/branch_cond_unit.sv
// Branch condition unit: registered S/Z/C/V flags, 16 branch conditions, hardware loop counter.
// Latency: branch at cycle N -> one-cycle redirect pulse with target at N+1.
// No backpressure: a branch is accepted every cycle and each taken branch gives its own pulse.
module branch_cond_unit #(
  parameter int WIDTH    = 16,
  parameter int LC_WIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flagWe,
  input  logic [WIDTH-1:0]    i_result,
  input  logic                i_carry,
  input  logic                i_ovf,
  input  logic                i_jValid,
  input  logic [3:0]          i_jCode,
  input  logic [WIDTH-1:0]    i_jTarget,
  input  logic                i_lcLoad,
  input  logic [LC_WIDTH-1:0] i_lcVal,
  output logic [3:0]          o_flags,
  output logic                o_redirect,
  output logic [WIDTH-1:0]    o_target,
  output logic                o_lcZero
);

  localparam logic [3:0] CODE_LNZ = 4'd15;

  logic [3:0]          flags_q;
  logic [LC_WIDTH-1:0] lc_q;
  logic                redirect_q;
  logic [WIDTH-1:0]    target_q;
  logic                lc_zero_q;

  logic [3:0]          new_flags;
  logic [3:0]          eval_flags;
  logic                flag_s, flag_z, flag_c, flag_v;
  logic [LC_WIDTH-1:0] lc_eff;
  logic [LC_WIDTH-1:0] lc_next;
  logic                is_lnz;
  logic                cond_true;

  // Incoming flags; a flag write in the same cycle as a branch is forwarded to the evaluation.
  assign new_flags  = {i_result[WIDTH-1], ~|i_result, i_carry, i_ovf};
  assign eval_flags = i_flagWe ? new_flags : flags_q;
  assign flag_s     = eval_flags[3];
  assign flag_z     = eval_flags[2];
  assign flag_c     = eval_flags[1];
  assign flag_v     = eval_flags[0];

  // A same-cycle load is what an LNZ decrements.
  assign lc_eff = i_lcLoad ? i_lcVal : lc_q;
  assign is_lnz = i_jValid && (i_jCode == CODE_LNZ);

  // Condition decode over the evaluation flag set.
  always_comb begin
    cond_true = 1'b0;
    case (i_jCode)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = flag_z;
      4'd2:    cond_true = ~flag_z;
      4'd3:    cond_true = flag_c;
      4'd4:    cond_true = ~flag_c;
      4'd5:    cond_true = flag_s;
      4'd6:    cond_true = ~flag_s;
      4'd7:    cond_true = flag_v;
      4'd8:    cond_true = ~flag_v;
      4'd9:    cond_true = flag_c & ~flag_z;
      4'd10:   cond_true = ~flag_c | flag_z;
      4'd11:   cond_true = (flag_s == flag_v);
      4'd12:   cond_true = (flag_s != flag_v);
      4'd13:   cond_true = ~flag_z & (flag_s == flag_v);
      4'd14:   cond_true = flag_z | (flag_s != flag_v);
      default: cond_true = (lc_eff != '0);
    endcase
  end

  // Next loop counter: LNZ decrements (saturating at 0), a plain load writes, otherwise hold.
  always_comb begin
    lc_next = lc_q;
    if (is_lnz) begin
      lc_next = (lc_eff != '0) ? (lc_eff - LC_WIDTH'(1)) : '0;
    end else if (i_lcLoad) begin
      lc_next = i_lcVal;
    end
  end

  // Flag register, written only on its enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      flags_q <= 4'b0000;
    end else if (i_flagWe) begin
      flags_q <= new_flags;
    end
  end

  // Loop counter and its zero indication, both reflecting the post-edge counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lc_q      <= '0;
      lc_zero_q <= 1'b1;
    end else begin
      lc_q      <= lc_next;
      lc_zero_q <= (lc_next == '0);
    end
  end

  // Redirect pulse for each taken branch; target captured on every branch, taken or not.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      redirect_q <= i_jValid & cond_true;
      if (i_jValid) begin
        target_q <= i_jTarget;
      end
    end
  end

  assign o_flags    = flags_q;
  assign o_redirect = redirect_q;
  assign o_target   = target_q;
  assign o_lcZero   = lc_zero_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit with an expectation queue.
// Latency: each step drives one cycle and checks the registered outputs 1 time unit after the edge.
// No backpressure in the DUT; the queue holds one expectation per driven cycle.
module tb_branch_cond_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_flagWe;
  logic [15:0] i_result;
  logic        i_carry;
  logic        i_ovf;
  logic        i_jValid;
  logic [3:0]  i_jCode;
  logic [15:0] i_jTarget;
  logic        i_lcLoad;
  logic [15:0] i_lcVal;
  logic [3:0]  o_flags;
  logic        o_redirect;
  logic [15:0] o_target;
  logic        o_lcZero;

  typedef struct {
    string      tag;
    logic       redirect;
    logic [15:0] target;
    logic [3:0] flags;
    logic       lc_zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  branch_cond_unit #(.WIDTH(16), .LC_WIDTH(16)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_flagWe  (i_flagWe),
    .i_result  (i_result),
    .i_carry   (i_carry),
    .i_ovf     (i_ovf),
    .i_jValid  (i_jValid),
    .i_jCode   (i_jCode),
    .i_jTarget (i_jTarget),
    .i_lcLoad  (i_lcLoad),
    .i_lcVal   (i_lcVal),
    .o_flags   (o_flags),
    .o_redirect(o_redirect),
    .o_target  (o_target),
    .o_lcZero  (o_lcZero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic rd, input logic [15:0] tg,
                      input logic [3:0] fl, input logic lz);
    exp_t e;
    e.tag = tag; e.redirect = rd; e.target = tg; e.flags = fl; e.lc_zero = lz;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({e.tag, ".redirect"}, {15'd0, o_redirect}, {15'd0, e.redirect});
      chk({e.tag, ".target"},   o_target,            e.target);
      chk({e.tag, ".flags"},    {12'd0, o_flags},    {12'd0, e.flags});
      chk({e.tag, ".lcZero"},   {15'd0, o_lcZero},   {15'd0, e.lc_zero});
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then check them.
  task automatic step(input string tag,
                      input logic fwe, input logic [15:0] res, input logic c, input logic v,
                      input logic jv, input logic [3:0] code, input logic [15:0] tgt,
                      input logic ld, input logic [15:0] lval,
                      input logic e_rd, input logic [15:0] e_tg, input logic [3:0] e_fl,
                      input logic e_lz);
    i_flagWe = fwe; i_result = res; i_carry = c; i_ovf = v;
    i_jValid = jv; i_jCode = code; i_jTarget = tgt;
    i_lcLoad = ld; i_lcVal = lval;
    push(tag, e_rd, e_tg, e_fl, e_lz);
    @(posedge i_clk);
    #1;
    pop_check();
  endtask

  initial begin
    i_rst = 1'b0;
    i_flagWe = 1'b0; i_result = '0; i_carry = 1'b0; i_ovf = 1'b0;
    i_jValid = 1'b0; i_jCode = '0; i_jTarget = '0; i_lcLoad = 1'b0; i_lcVal = '0;
    #1 i_rst = 1'b1;
    #2;
    push("reset", 1'b0, 16'h0000, 4'b0000, 1'b1);
    pop_check();
    @(negedge i_clk);
    i_rst = 1'b0;

    //    tag        fwe res      c    v    jv   code   target    ld   lval    rd   target    flags    lz
    step("flags0",   1, 16'h0000, 1, 0,   0, 4'd0,  16'h0000, 0, 16'd0,  0, 16'h0000, 4'b0110, 1);
    step("eq",       0, 16'h0000, 0, 0,   1, 4'd1,  16'h0040, 0, 16'd0,  1, 16'h0040, 4'b0110, 1);
    step("ne",       0, 16'h0000, 0, 0,   1, 4'd2,  16'h0044, 0, 16'd0,  0, 16'h0044, 4'b0110, 1);
    step("lt_fwd",   1, 16'h8000, 0, 0,   1, 4'd12, 16'h0080, 0, 16'd0,  1, 16'h0080, 4'b1000, 1);
    step("ge_ovf",   1, 16'h7FFF, 0, 1,   1, 4'd11, 16'h0100, 0, 16'd0,  0, 16'h0100, 4'b0001, 1);
    step("lt_ovf",   0, 16'h0000, 0, 0,   1, 4'd12, 16'h0104, 0, 16'd0,  1, 16'h0104, 4'b0001, 1);
    step("gt_zero",  1, 16'h0000, 0, 0,   1, 4'd13, 16'h0200, 0, 16'd0,  0, 16'h0200, 4'b0100, 1);
    step("le_zero",  0, 16'h0000, 0, 0,   1, 4'd14, 16'h0204, 0, 16'd0,  1, 16'h0204, 4'b0100, 1);
    step("hi",       1, 16'h0001, 1, 0,   1, 4'd9,  16'h0300, 0, 16'd0,  1, 16'h0300, 4'b0010, 1);
    step("ls",       0, 16'h0000, 0, 0,   1, 4'd10, 16'h0304, 0, 16'd0,  0, 16'h0304, 4'b0010, 1);
    step("al",       0, 16'h0000, 0, 0,   1, 4'd0,  16'h0308, 0, 16'd0,  1, 16'h0308, 4'b0010, 1);
    step("idle",     0, 16'h0000, 0, 0,   0, 4'd0,  16'h0FFF, 0, 16'd0,  0, 16'h0308, 4'b0010, 1);
    step("lc_load3", 0, 16'h0000, 0, 0,   0, 4'd0,  16'h0000, 1, 16'd3,  0, 16'h0308, 4'b0010, 0);
    step("lnz_1",    0, 16'h0000, 0, 0,   1, 4'd15, 16'h0400, 0, 16'd0,  1, 16'h0400, 4'b0010, 0);
    step("lnz_2",    0, 16'h0000, 0, 0,   1, 4'd15, 16'h0404, 0, 16'd0,  1, 16'h0404, 4'b0010, 0);
    step("lnz_3",    0, 16'h0000, 0, 0,   1, 4'd15, 16'h0408, 0, 16'd0,  1, 16'h0408, 4'b0010, 1);
    step("lnz_4",    0, 16'h0000, 0, 0,   1, 4'd15, 16'h040C, 0, 16'd0,  0, 16'h040C, 4'b0010, 1);
    step("lnz_5",    0, 16'h0000, 0, 0,   1, 4'd15, 16'h0410, 0, 16'd0,  0, 16'h0410, 4'b0010, 1);
    step("lnz_ld1",  0, 16'h0000, 0, 0,   1, 4'd15, 16'h0500, 1, 16'd1,  1, 16'h0500, 4'b0010, 1);
    step("lnz_ld0",  0, 16'h0000, 0, 0,   1, 4'd15, 16'h0504, 1, 16'd0,  0, 16'h0504, 4'b0010, 1);
    step("eq_ld5",   0, 16'h0000, 0, 0,   1, 4'd1,  16'h0600, 1, 16'd5,  0, 16'h0600, 4'b0010, 0);
    step("al_lc5",   0, 16'h0000, 0, 0,   1, 4'd0,  16'h0700, 0, 16'd0,  1, 16'h0700, 4'b0010, 0);

    // Mid-cycle reset with a taken pulse showing and the counter at 5.
    #2;
    i_rst = 1'b1;
    #1;
    push("async_rst", 1'b0, 16'h0000, 4'b0000, 1'b1);
    pop_check();
    @(negedge i_clk);
    i_rst = 1'b0;

    step("post_lnz", 0, 16'h0000, 0, 0,   1, 4'd15, 16'h0800, 0, 16'd0,  0, 16'h0800, 4'b0000, 1);
    step("post_al",  0, 16'h0000, 0, 0,   1, 4'd0,  16'h0804, 0, 16'd0,  1, 16'h0804, 4'b0000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
